hilo_mult_unit: RTL and testbench
=================================

Name: hilo_mult_unit

Overview:
Execute-stage HI/LO register file with an iterative 32x32 multiplier. It consumes the multiply, accumulate and move-to-HI/LO decode produced by the ALU control stage (mult, multu, madd, msub, mthi, mtlo) and owns the architectural HI and LO registers. It supplies HI/LO read data for mfhi/mflo and raises a pipeline stall while a multi-cycle multiply is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  reset; synchronous, active-low
OpValid  in  1  HLOp is valid this cycle
HLOp  in  3  0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MSUB, 5 MTHI, 6 MTLO, 7 NOP
OpA  in  WIDTH  rs operand
OpB  in  WIDTH  rt operand (ignored for MTHI/MTLO)
ReadReq  in  1  mfhi/mflo in EX requests HI/LO
Busy  out  1  multiplier FSM not IDLE
Stall  out  1  freeze upstream stages
HiOut  out  WIDTH  current HI register
LoOut  out  WIDTH  current LO register

Behaviour:
- Reset (Rst_n=0 at an edge): state=IDLE; HI=LO=0; counter=0; Busy=0.
  - Stall is combinational, so it reads 0 once Busy=0.
  - Reset mid-operation aborts the multiply with no HI/LO write.
- FSM states:
  - IDLE to MUL: OpValid and HLOp is 1..4 at edge E0. Latch |OpA| and |OpB| (signed ops only), the result sign, the op kind, and counter=0.
  - MUL: 32 shift-add iterations at edges E1..E32, 1 multiplier bit per edge into a 64-bit product register. Counter increments; at counter=31 go to FIN.
  - FIN at edge E33:
    - Negate the product if the sign flag is set.
    - MULT/MULTU: {HI,LO} = product.
    - MADD: {HI,LO} = {HI,LO} + product.
    - MSUB: {HI,LO} = {HI,LO} - product.
    - All arithmetic is mod 2^64. Go to IDLE.
- Latency: issue edge E0, HI/LO updated at E33. Busy=1 from after E0 until after E33, i.e. exactly 33 cycles.
- Signed magnitude: 0x80000000 has magnitude 2^31 and is handled unsigned; no overflow.
- MTHI/MTLO in IDLE: HI (or LO) = OpA at that edge; single cycle; Busy stays 0.
- HLOp 0 or 7, or OpValid=0: no state change.
- Stall = Busy & (OpValid | ReadReq).
  - An op presented while Busy is held, not dropped. It is accepted at the first edge with Busy=0 (E34 for back-to-back ops).
  - No operation is accepted while Busy.
- HiOut/LoOut drive the registers directly. No internal forwarding: a read in the cycle after E33 sees new values.
- HI/LO are never written while Busy, except by FIN; the accumulate uses the values at FIN.

Decomposition:
- Shared package (processor-wide defs): HLOp encodings, WIDTH default, FSM state encoding (IDLE/MUL/FIN).
- One sub-module: seq_mult_core, the unsigned shift-add datapath (product register, counter, done flag).
- Top level holds sign handling, the accumulate adder/subtractor, HI/LO registers, FSM control and Stall.

Test Plan:
- Reset: hold Rst_n=0 for 2 edges -> HiOut=0, LoOut=0, Busy=0, Stall=0.
- MULT OpA=0xFFFFFFFF, OpB=0x00000002 -> Busy high exactly 33 cycles; after E33 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- Accumulate sequence -> each step checked:
  - MTHI 5 -> HI=5.
  - MTLO 7 -> LO=7.
  - MADD 3, 4 -> HI=0x5, LO=0x13.
  - MSUB 0xFFFFFFFF, 1 -> HI=0x5, LO=0x14.
- Stall handshake: MULT at E0; ReadReq=1 from E1 -> Stall=1 through Busy and 0 after E33. A second MULT held from E2 is accepted at E34 and completes at E67.
- Boundaries:
  - MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
  - Rst_n=0 at E10 of a MULT -> Busy=0, HI=LO=0 after that edge, no later write.

Source files
------------

// File: rtl/hilo_mult_unit_pkg.sv
// Shared HI/LO unit definitions: operation encodings, default widths and FSM states.
package hilo_mult_unit_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultCntW  = 5;

  typedef enum logic [2:0] {
    HlNop   = 3'd0,
    HlMult  = 3'd1,
    HlMultu = 3'd2,
    HlMadd  = 3'd3,
    HlMsub  = 3'd4,
    HlMthi  = 3'd5,
    HlMtlo  = 3'd6,
    HlNop7  = 3'd7
  } hl_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StFin  = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage

// File: rtl/hilo_mult_unit_core.sv
// Unsigned shift-add multiplier datapath: one multiplier bit retired per step.
module seq_mult_core
  import hilo_mult_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               done_o
);

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sum;

  // Multiplier sits in the low half and shifts out as the partial product shifts in.
  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    sum     = '0;
    if (load_i) begin
      prod_d  = {{WIDTH{1'b0}}, mplier_i};
      mcand_d = mcand_i;
      cnt_d   = '0;
    end else if (step_i) begin
      sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_d = {sum, prod_q[WIDTH-1:1]};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prod_o = prod_q;
  assign done_o = step_i && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO register file with iterative signed/unsigned multiply and multiply-accumulate.
module hilo_mult_unit
  import hilo_mult_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             OpValid,
  input  logic [2:0]       HLOp,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             ReadReq,
  output logic             Busy,
  output logic             Stall,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d;
  hl_op_e             kind_q, kind_d;

  logic               accept, is_signed, done;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, prod_s, acc, res;

  assign accept    = OpValid && (state_q == StIdle) && is_mul_op(HLOp);
  assign is_signed = (HLOp != HlMultu);
  // Magnitude of the most negative value is itself when read as unsigned.
  assign mag_a     = (is_signed && OpA[WIDTH-1]) ? -OpA : OpA;
  assign mag_b     = (is_signed && OpB[WIDTH-1]) ? -OpB : OpB;

  seq_mult_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i    (Clk),
    .rst_ni   (Rst_n),
    .load_i   (accept),
    .step_i   (state_q == StMul),
    .mcand_i  (mag_a),
    .mplier_i (mag_b),
    .prod_o   (prod),
    .done_o   (done)
  );

  assign prod_s = neg_q ? -prod : prod;
  assign acc    = {hi_q, lo_q};

  always_comb begin
    res = prod_s;
    unique case (kind_q)
      HlMadd:  res = acc + prod_s;
      HlMsub:  res = acc - prod_s;
      default: res = prod_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    kind_d  = kind_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StMul;
          neg_d   = is_signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
          kind_d  = hl_op_e'(HLOp);
        end else if (OpValid && (HLOp == HlMthi)) begin
          hi_d = OpA;
        end else if (OpValid && (HLOp == HlMtlo)) begin
          lo_d = OpA;
        end
      end
      StMul: begin
        if (done) state_d = StFin;
      end
      StFin: begin
        {hi_d, lo_d} = res;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      kind_q  <= HlNop;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      kind_q  <= kind_d;
    end
  end

  assign Busy  = (state_q != StIdle);
  assign Stall = Busy && (OpValid || ReadReq);
  assign HiOut = hi_q;
  assign LoOut = lo_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit: expected {HI,LO} queued at issue, compared at completion.
module tb_hilo_mult_unit;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Rst_n, OpValid, ReadReq;
  logic [2:0]   HLOp;
  logic [W-1:0] OpA, OpB;
  logic         Busy, Stall;
  logic [W-1:0] HiOut, LoOut;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] sb[$];
  logic [63:0] model = '0;

  hilo_mult_unit #(
    .WIDTH (32),
    .CNT_W (5)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .OpValid (OpValid),
    .HLOp    (HLOp),
    .OpA     (OpA),
    .OpB     (OpB),
    .ReadReq (ReadReq),
    .Busy    (Busy),
    .Stall   (Stall),
    .HiOut   (HiOut),
    .LoOut   (LoOut)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: sign-extend to 64 bits and multiply mod 2^64.
  function automatic logic [63:0] mul_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] ea, eb, p;
    if (op == 3'd2) begin
      ea = {32'b0, a};
      eb = {32'b0, b};
    end else begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end
    p = ea * eb;
    case (op)
      3'd3:    return acc + p;
      3'd4:    return acc - p;
      default: return p;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    OpValid = 1'b1;
    HLOp    = op;
    OpA     = a;
    OpB     = b;
    @(posedge Clk);
    #1;
    OpValid = 1'b0;
    HLOp    = 3'd0;
  endtask

  task automatic pop_cmp(input string tag);
    if (sb.size() == 0) begin
      check_val({tag, " sb_empty"}, 64'd1, 64'd0);
    end else begin
      check_val(tag, {HiOut, LoOut}, sb.pop_front());
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    @(negedge Clk);
    while (Busy && cyc < 200) begin
      cyc++;
      @(negedge Clk);
    end
    check_val({tag, " busy_cycles"}, 64'(cyc), 64'd33);
    pop_cmp(tag);
  endtask

  task automatic run_mul(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    model = mul_model(op, a, b, model);
    sb.push_back(model);
    drive(op, a, b);
    wait_done(tag);
  endtask

  task automatic run_move(input string tag, input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd5) model[63:32] = a;
    else            model[31:0]  = a;
    sb.push_back(model);
    drive(op, a, 32'hDEAD_BEEF);
    @(negedge Clk);
    check_val({tag, " busy"}, 64'(Busy), 64'd0);
    pop_cmp(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_hi;
    logic [63:0] exp1, exp2;
    Rst_n = 1'b0; OpValid = 1'b0; ReadReq = 1'b0; HLOp = 3'd0; OpA = '0; OpB = '0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    check_val("reset hi", 64'(HiOut), 64'd0);
    check_val("reset lo", 64'(LoOut), 64'd0);
    check_val("reset busy", 64'(Busy), 64'd0);
    check_val("reset stall", 64'(Stall), 64'd0);

    run_mul("mult_neg", 3'd1, 32'hFFFF_FFFF, 32'h2);
    check_val("mult_neg const", {HiOut, LoOut}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_mul("multu", 3'd2, 32'hFFFF_FFFF, 32'h2);
    check_val("multu const", {HiOut, LoOut}, 64'h0000_0001_FFFF_FFFE);

    run_move("mthi", 3'd5, 32'd5);
    run_move("mtlo", 3'd6, 32'd7);
    run_mul("madd", 3'd3, 32'd3, 32'd4);
    check_val("madd const", {HiOut, LoOut}, 64'h0000_0005_0000_0013);
    run_mul("msub", 3'd4, 32'hFFFF_FFFF, 32'd1);
    check_val("msub const", {HiOut, LoOut}, 64'h0000_0005_0000_0014);

    // NOP encodings and unqualified ops leave state untouched.
    drive(3'd7, 32'h1234, 32'h5678);
    @(negedge Clk);
    check_val("nop7", {63'(HiOut == 32'd5 && LoOut == 32'h14), Busy}, 64'd2);
    @(negedge Clk);
    OpA = 32'h55; OpB = 32'h66; HLOp = 3'd1;
    @(negedge Clk);
    check_val("novalid", {HiOut, LoOut, 1'b0} >> 1, model);
    check_val("novalid busy", 64'(Busy), 64'd0);
    HLOp = 3'd0;

    run_mul("min_sq", 3'd1, 32'h8000_0000, 32'h8000_0000);
    check_val("min_sq const", {HiOut, LoOut}, 64'h4000_0000_0000_0000);

    for (int i = 0; i < 4; i++) begin
      logic [2:0] op;
      op = 3'(1 + (i % 4));
      run_mul($sformatf("rnd%0d", i), op, $urandom, $urandom);
    end

    // Stall handshake with a second MULT held from E2.
    exp1 = mul_model(3'd1, 32'h0001_2345, 32'hFFFF_FF00, model);
    exp2 = mul_model(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, exp1);
    model = exp2;
    sb.push_back(exp1);
    sb.push_back(exp2);
    drive(3'd1, 32'h0001_2345, 32'hFFFF_FF00);
    @(posedge Clk);
    #1 ReadReq = 1'b1;
    @(posedge Clk);
    #1;
    OpValid = 1'b1; HLOp = 3'd1; OpA = 32'h7FFF_FFFF; OpB = 32'h7FFF_FFFF;
    stall_hi = 0;
    for (int i = 2; i < 33; i++) begin
      @(negedge Clk);
      if (Stall) stall_hi++;
    end
    check_val("stall held", 64'(stall_hi), 64'd31);
    @(posedge Clk);
    @(negedge Clk);
    check_val("stall drop", 64'(Stall), 64'd0);
    pop_cmp("stall first");
    @(posedge Clk);
    #1;
    OpValid = 1'b0; HLOp = 3'd0; ReadReq = 1'b0;
    wait_done("stall second");

    // Reset at E10 aborts the multiply without writing HI/LO.
    drive(3'd1, 32'h1111_1111, 32'h2222_2222);
    repeat (9) @(posedge Clk);
    #1 Rst_n = 1'b0;
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    model = '0;
    sb.delete();
    @(negedge Clk);
    check_val("abort busy", 64'(Busy), 64'd0);
    check_val("abort hilo", {HiOut, LoOut}, model);
    repeat (40) @(negedge Clk);
    check_val("abort later", {HiOut, LoOut, 1'b0, Busy}, 66'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
